// File: rtl/x_byte_pkg.sv
// Shared definitions for the x_byte serializer/deserializer pair.
// Contents: byte width, default word length in bytes, serializer FSM state type.
package x_byte_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned NUM_BYTES_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2
    } x_byte_ser_state_t;

endpackage

// File: rtl/x_byte_ser_syn_test.sv
// Synthesis test wrapper for x_byte_ser: the input word is assembled in a
// register from a byte-wide pin port, and all outputs fold into one pin.
// Macro X_BYTE_SER_PARITY_EN passes through to x_byte_ser.
//
// Ports:
//   i_clk    in   clock
//   i_rst    in   asynchronous reset, active low
//   i_load   in   shift i_din into the word register
//   i_din    in   byte shifted into the word register LSB end
//   i_valid  in   word valid to the serializer
//   i_ready  in   downstream ready to the serializer
//   o_xor    out  registered XOR of all serializer outputs
module x_byte_ser_syn_test
    import x_byte_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_din,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic              o_xor
);

    localparam int unsigned WORD_W = NUM_BYTES_DEFAULT * BYTE_W;

    logic [WORD_W-1:0] data_q, data_d;
    logic              xor_q,  xor_d;
    logic              ready_c;
    logic              valid_c;
    logic              busy_c;
    logic [BYTE_W-1:0] byte_c;

    x_byte_ser #(
        .NUM_BYTES (NUM_BYTES_DEFAULT)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (ready_c),
        .i_data  (data_q),
        .o_valid (valid_c),
        .i_ready (i_ready),
        .o_byte  (byte_c),
        .o_busy  (busy_c)
    );

    // Word loader and output fold.
    always_comb begin
        data_d = data_q;
        if (i_load) begin
            data_d = {data_q[WORD_W-BYTE_W-1:0], i_din};
        end
        xor_d = ^{ready_c, valid_c, busy_c, byte_c};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_q <= '0;
            xor_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            xor_q  <= xor_d;
        end
    end

    assign o_xor = xor_q;

endmodule

// File: rtl/x_byte_ser.sv
// x_byte_ser: byte serializer. Accepts a NUM_BYTES*8-bit word on a valid/ready
// handshake and emits it MSB byte first on a downstream valid/ready handshake.
//
// Optional feature macro: X_BYTE_SER_PARITY_EN -- appends one byte equal to the
// XOR of all data bytes after the last data byte.
//
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous reset, active low
//   i_valid  in   input word valid
//   o_ready  out  word accepted this cycle when i_valid (combinational on i_ready)
//   i_data   in   input word
//   o_valid  out  o_byte holds a valid byte
//   i_ready  in   downstream takes the byte this cycle
//   o_byte   out  current output byte
//   o_busy   out  a word is in flight
module x_byte_ser
    import x_byte_pkg::*;
#(
    parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0] i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [BYTE_W-1:0]           o_byte,
    output logic                        o_busy
);

    localparam int unsigned WORD_W = NUM_BYTES * BYTE_W;
    localparam int unsigned CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    x_byte_ser_state_t  state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef X_BYTE_SER_PARITY_EN
    logic [BYTE_W-1:0]  par_q,   par_d;
`endif

    logic               xfer_c;
    logic               accept_c;
    logic               last_c;
    logic [BYTE_W-1:0]  cur_byte_c;

    // The byte on the wire is always the top of the shift register; in PAR the
    // parity byte is loaded there so the output path has a single source.
    assign cur_byte_c = shreg_q[WORD_W-1 -: BYTE_W];
    assign o_byte     = cur_byte_c;
    assign o_valid    = (state_q != IDLE);
    assign o_busy     = o_valid;

    // Final beat of the current word: parity byte if enabled, else last data byte.
`ifdef X_BYTE_SER_PARITY_EN
    assign last_c = (state_q == PAR);
`else
    assign last_c = (state_q == SEND) && (cnt_q == LAST_CNT);
`endif

    assign o_ready  = (state_q == IDLE) | (last_c & i_ready);
    assign xfer_c   = o_valid & i_ready;
    assign accept_c = i_valid & o_ready;

    // Next-state: FSM, shift register, counter and parity accumulator.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef X_BYTE_SER_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SEND;
                    shreg_d = i_data;
                    cnt_d   = '0;
`ifdef X_BYTE_SER_PARITY_EN
                    par_d   = '0;
`endif
                end
            end
            SEND: begin
                if (xfer_c) begin
`ifdef X_BYTE_SER_PARITY_EN
                    par_d = par_q ^ cur_byte_c;
`endif
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
`ifdef X_BYTE_SER_PARITY_EN
                        state_d = PAR;
                        shreg_d = WORD_W'(par_d) << (WORD_W - BYTE_W);
`else
                        if (accept_c) begin
                            shreg_d = i_data;
                        end else begin
                            state_d = IDLE;
                            shreg_d = shreg_q << BYTE_W;
                        end
`endif
                    end else begin
                        shreg_d = shreg_q << BYTE_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef X_BYTE_SER_PARITY_EN
            PAR: begin
                if (xfer_c) begin
                    cnt_d = '0;
                    if (accept_c) begin
                        state_d = SEND;
                        shreg_d = i_data;
                        par_d   = '0;
                    end else begin
                        state_d = IDLE;
                        shreg_d = shreg_q << BYTE_W;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef X_BYTE_SER_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef X_BYTE_SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: doc/x_byte_ser.md
# x_byte_ser

Byte serializer: the transmit-side counterpart of `x_byte_des`. It accepts a 64-bit word through a valid/ready handshake and emits it as a stream of bytes, most-significant byte first, under a downstream valid/ready handshake. Feeding its byte stream into `x_byte_des` (`o_byte`→`i_cmd`, handshake-qualified `o_valid`→`i_valid`) reproduces the original word. It sits between the word-level logic and the byte-wide link or UART transmitter.

## Interface
- `NUM_BYTES`, default 8: bytes per word. Word width is `NUM_BYTES*8`.
- `i_clk`  in  1: clock; all logic is rising-edge.
- `i_rst`  in  1: reset, asynchronous, active-low.
- `i_valid`  in  1: input word valid.
- `o_ready`  out  1: block accepts a word this cycle.
- `i_data`  in  `NUM_BYTES*8`: input word.
- `o_valid`  out  1: `o_byte` holds a valid byte.
- `i_ready`  in  1: downstream accepts the byte this cycle.
- `o_byte`  out  8: current output byte.
- `o_busy`  out  1: a word is in flight.

## Operation
- Word accept: `i_valid & o_ready`. Byte transfer: `o_valid & i_ready`.
- FSM states:
  - `IDLE`: no word held.
  - `SEND`: bytes of the held word are being emitted.
  - `PAR`: parity byte is being emitted; exists only with the macro defined.
- `IDLE` → `SEND` on word accept:
  - Latch `i_data` into the shift register.
  - Set byte counter to 0.
  - `o_byte` = `i_data[63:56]` from the next cycle.
- In `SEND`, each byte transfer shifts the register left by 8 and increments the counter.
- Last byte is counter = `NUM_BYTES-1`. On its transfer:
  - Go to `PAR` if the macro is enabled.
  - Else, if a new word is accepted in the same cycle, reload and stay in `SEND`.
  - Else, go to `IDLE`.
- `PAR` → `IDLE` on transfer, or → `SEND` if a word is accepted in the same cycle.
- `o_ready` = `IDLE` | (final byte of word or parity is in place & `i_ready`). This is combinational on `i_ready`, which gives back-to-back words with no bubble.
- `o_valid` = `SEND` | `PAR`. `o_busy` = `o_valid`.
- Backpressure: while `o_valid & !i_ready`, `o_byte`, the state and the counter hold unchanged.
- Counter width is `$clog2(NUM_BYTES)`. There is no wrap beyond `NUM_BYTES-1`.
- `i_data` is ignored outside an accept.
- `i_valid` while `o_ready` is low has no effect. The upstream block holds its word until accepted.

## Timing
- Reset values: state `IDLE`, `o_valid` 0, `o_byte` 0x00, `o_busy` 0, `o_ready` 1, counter 0, parity accumulator 0.
- Latency: word accepted at cycle N gives first byte valid at N+1.
- With `i_ready` held high, a word occupies exactly `NUM_BYTES` cycles (`NUM_BYTES+1` with parity).
- Reset asserted mid-word: the word is discarded and there is no partial completion. Outputs reach reset values asynchronously.
- Reset deassertion is synchronized externally; the block assumes it is clean.

## Configuration
- Macro `X_BYTE_SER_PARITY_EN`.
- Defined:
  - After the last data byte, one extra byte is sent: the XOR of all `NUM_BYTES` data bytes.
  - It is accumulated as bytes are transferred and cleared on word accept.
- Undefined:
  - No `PAR` state and no accumulator.
  - `o_ready` reopens on the last data byte transfer.

## Structure
- Shared package `x_byte_pkg`:
  - `BYTE_W` = 8.
  - Default `NUM_BYTES` = 8.
  - FSM state enum `x_byte_ser_state_t` (`IDLE`, `SEND`, `PAR`).
- Single module with no sub-module. The shift register, counter, FSM and parity accumulator are small enough to stay inline.
- Synthesis test wrapper `x_byte_ser_syn_test`:
  - Drives `i_data` from a register loaded from pins.
  - XOR-reduces the outputs to one pin.

## Test plan
- Reset, then accept `0x0123456789ABCDEF` with `i_ready`=1 → bytes 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles. With parity enabled, a ninth byte 0x00 follows. `o_ready` is low throughout and reopens on the final transfer.
- Word `0x00000000000000A5` with parity enabled → seven 0x00 bytes, then A5, then parity A5.
- Backpressure: drop `i_ready` for 3 cycles after byte 2 → `o_byte` holds 0x45 stable, and the sequence then resumes with no byte lost or duplicated.
- Back-to-back: `i_valid` held high with words A then B → B's first byte directly follows A's last byte (or parity) with zero idle cycles.
- Reset asserted while byte 4 is pending → `o_valid` 0 and `o_ready` 1 immediately. The next word is sent complete from its MSB.
- Round trip: chain `x_byte_ser` → `x_byte_des` over 100 random words → deserializer output equals each input word (parity disabled).
